// File: rtl/johnson_phase_monitor_if.sv
// rtl/johnson_phase_monitor_if.sv - Johnson code input and decoded phase/status bundle
interface johnson_phase_monitor_if #(
    parameter int N     = 4,
    parameter int REV_W = 8
);
    localparam int IDX_W = $clog2(2 * N);

    logic [N-1:0]     q_in;
    logic             clr_err;
    logic [2*N-1:0]   phase_onehot;
    logic [IDX_W-1:0] phase_idx;
    logic             valid;
    logic             locked;
    logic             rev_pulse;
    logic [REV_W-1:0] rev_count;
    logic             step_err;
    logic             code_err;

    modport master (
        output q_in, clr_err,
        input  phase_onehot, phase_idx, valid, locked, rev_pulse, rev_count, step_err, code_err
    );

    modport slave (
        input  q_in, clr_err,
        output phase_onehot, phase_idx, valid, locked, rev_pulse, rev_count, step_err, code_err
    );
endinterface

// File: rtl/johnson_phase_monitor.sv
// rtl/johnson_phase_monitor.sv - Johnson code decoder with lock, revolution count and step checking
// Optional feature macro: JOHNSON_PHASE_MONITOR_HOLD_ALLOW_EN (repeated code treated as a legal stall)
module johnson_phase_monitor #(
    parameter int N        = 4,
    parameter int REV_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    johnson_phase_monitor_if.slave  bus
);
    localparam int IDX_W = $clog2(2 * N);
    localparam int LC_W  = $clog2(2 * N + 1);

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_LOCKED  = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;

    // Bit b of the phase-k code: a run of ones filling from the LSB, then draining from the LSB.
    function automatic logic [N-1:0] code_of(input int k);
        logic [N-1:0] c;
        for (int b = 0; b < N; b++) begin
            c[b] = (k <= N) ? (b < k) : (b >= k - N);
        end
        return c;
    endfunction

    logic [N-1:0]     q_r_q;
    logic [N-1:0]     prev_q;
    logic             loaded_q;
    logic             have_prev_q;
    logic [1:0]       state_q, state_d;
    logic [LC_W-1:0]  lc_q, lc_d;
    logic [2*N-1:0]   onehot_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             locked_q;
    logic             rev_pulse_q, rev_pulse_d;
    logic [REV_W-1:0] rev_count_q, rev_count_d;
    logic             step_err_q, step_err_d;
    logic             code_err_q, code_err_d;

    logic             dec_legal;
    logic [IDX_W-1:0] dec_idx;
    logic [2*N-1:0]   dec_onehot;

    always_comb begin
        dec_legal  = 1'b0;
        dec_idx    = '0;
        dec_onehot = '0;
        for (int k = 0; k < 2 * N; k++) begin
            if (q_r_q == code_of(k)) begin
                dec_legal     = 1'b1;
                dec_idx       = k[IDX_W-1:0];
                dec_onehot[k] = 1'b1;
            end
        end
    end

    logic [N-1:0] succ_code;
    logic         step_valid;
    logic         is_succ;
    logic         is_bad;
    logic         succ_step;
    logic         bad_step;
    logic         wrap_step;

    // The Johnson shift maps the legal set onto itself, so a legal current code
    // equal to the shifted predecessor is a legal successor step.
    assign succ_code  = {prev_q[N-2:0], ~prev_q[N-1]};
    assign step_valid = loaded_q && have_prev_q;
    assign is_succ    = dec_legal && (q_r_q == succ_code);
`ifdef JOHNSON_PHASE_MONITOR_HOLD_ALLOW_EN
    assign is_bad     = !is_succ && !(dec_legal && (q_r_q == prev_q));
`else
    assign is_bad     = !is_succ;
`endif
    assign succ_step  = step_valid && is_succ;
    assign bad_step   = step_valid && is_bad;
    assign wrap_step  = succ_step && (dec_idx == '0);

    always_comb begin
        state_d     = state_q;
        lc_d        = lc_q;
        step_err_d  = 1'b0;
        code_err_d  = code_err_q;
        rev_pulse_d = 1'b0;
        rev_count_d = rev_count_q;
        case (state_q)
            ST_ACQUIRE: begin
                if (succ_step) begin
                    lc_d = lc_q + LC_W'(1);
                    if (lc_q + LC_W'(1) >= LC_W'(LOCK_CNT)) begin
                        state_d = ST_LOCKED;
                    end
                end else if (bad_step) begin
                    lc_d = '0;
                end
            end
            ST_LOCKED: begin
                if (bad_step) begin
                    step_err_d = 1'b1;
                    code_err_d = 1'b1;
                    lc_d       = '0;
                    state_d    = ST_FAULT;
                end else if (wrap_step) begin
                    rev_pulse_d = 1'b1;
                    rev_count_d = rev_count_q + REV_W'(1);
                end
            end
            ST_FAULT: begin
                // A fresh error in the same cycle as clr_err keeps the fault latched.
                if (bad_step) begin
                    code_err_d = 1'b1;
                end else if (bus.clr_err) begin
                    code_err_d = 1'b0;
                    lc_d       = '0;
                    state_d    = ST_ACQUIRE;
                end
            end
            default: begin
                state_d = ST_ACQUIRE;
                lc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r_q       <= '0;
            prev_q      <= '0;
            loaded_q    <= 1'b0;
            have_prev_q <= 1'b0;
            state_q     <= ST_ACQUIRE;
            lc_q        <= '0;
            onehot_q    <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            rev_pulse_q <= 1'b0;
            rev_count_q <= '0;
            step_err_q  <= 1'b0;
            code_err_q  <= 1'b0;
        end else begin
            q_r_q       <= bus.q_in;
            loaded_q    <= 1'b1;
            state_q     <= state_d;
            lc_q        <= lc_d;
            locked_q    <= (state_d == ST_LOCKED);
            rev_pulse_q <= rev_pulse_d;
            rev_count_q <= rev_count_d;
            step_err_q  <= step_err_d;
            code_err_q  <= code_err_d;
            if (loaded_q) begin
                prev_q      <= q_r_q;
                have_prev_q <= 1'b1;
                valid_q     <= dec_legal;
                onehot_q    <= dec_onehot;
                if (dec_legal) begin
                    idx_q <= dec_idx;
                end
            end
        end
    end

    assign bus.phase_onehot = onehot_q;
    assign bus.phase_idx    = idx_q;
    assign bus.valid        = valid_q;
    assign bus.locked       = locked_q;
    assign bus.rev_pulse    = rev_pulse_q;
    assign bus.rev_count    = rev_count_q;
    assign bus.step_err     = step_err_q;
    assign bus.code_err     = code_err_q;
endmodule
